// File: rtl/tf_pkg.sv
`default_nettype none
// ==== tf_pkg: load-FSM state type and width helpers for tf_rom_banked ====
// ==== Rev 1.0                                                          ====
package tf_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2
   } tf_state_e;

   function automatic int unsigned tf_cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Number of low counter bits that select the lane; zero for a single bank.
   function automatic int unsigned tf_lane_w(input int unsigned lanes);
      return (lanes > 1) ? $clog2(lanes) : 0;
   endfunction

   function automatic int unsigned tf_idx_w(input int unsigned rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tf_bank.sv
`default_nettype none
// ==== tf_bank: one block-RAM bank, single write port, registered read ====
// ==== Rev 1.0                                                         ====
module tf_bank
   import tf_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 28,
   parameter int unsigned ROWS   = 384
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] wr_row_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] rd_row_i,
   output logic [DATA_W-1:0] rd_data_o
);

   localparam int unsigned c_idx_w = tf_idx_w(ROWS);

   (* ram_style = "block" *) logic [DATA_W-1:0] mem_q [ROWS];
   logic [DATA_W-1:0]  rd_data_q;
   logic [c_idx_w-1:0] w_widx;
   logic [c_idx_w-1:0] w_ridx;

   assign w_widx = c_idx_w'(wr_row_i);
   assign w_ridx = c_idx_w'(rd_row_i);

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[w_widx] <= wr_data_i;
      end
   end

   // Only the read register is reset so the output starts at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (re_i) begin
         rd_data_q <= mem_q[w_ridx];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/tf_rom_banked.sv
`default_nettype none
// ==== tf_rom_banked: lane-interleaved twiddle store, streamed load, row reads ====
// ==== Rev 1.0                                                                 ====
module tf_rom_banked
   import tf_pkg::*;
#(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned DATA_W    = 28,
   parameter int unsigned DEPTH     = 768,
   parameter int unsigned NUM_LANES = 2,
   parameter int unsigned OUT_REG   = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ld_start,
   input  logic                          ld_valid,
   output logic                          ld_ready,
   input  logic [DATA_W-1:0]             ld_data,
   output logic                          loaded,
   input  logic                          rd_en,
   input  logic [ADDR_W-1:0]             rd_addr,
   output logic                          rd_valid,
   output logic [NUM_LANES*DATA_W-1:0]   rd_data,
   output logic                          rd_err
);

   localparam int unsigned c_bank_depth = DEPTH / NUM_LANES;
   localparam int unsigned c_cnt_w      = tf_cnt_w(DEPTH);
   localparam int unsigned c_lane_w     = tf_lane_w(NUM_LANES);
   localparam logic [ADDR_W:0]    c_rows_lim = (ADDR_W+1)'(c_bank_depth);
   localparam logic [c_cnt_w-1:0] c_last     = c_cnt_w'(DEPTH - 1);

   tf_state_e                        state_q, state_d;
   logic [c_cnt_w-1:0]               cnt_q, cnt_d;
   logic                             err_q, err_d;
   logic                             rv1_q;
   logic                             w_wr_fire;
   logic                             w_rd_acc;
   logic                             w_rd_rej;
   logic [ADDR_W-1:0]                w_wr_row;
   logic [NUM_LANES-1:0]             w_bank_we;
   logic [NUM_LANES-1:0][DATA_W-1:0] w_bank_dout;

   // A same-cycle ld_start restarts the load and drops the offered word.
   assign w_wr_fire = (state_q == ST_LOAD) && ld_valid && !ld_start;
   assign w_rd_acc  = rd_en && (state_q == ST_READY) && !ld_start
                      && ({1'b0, rd_addr} < c_rows_lim);
   assign w_rd_rej  = rd_en && !w_rd_acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rv1_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rv1_q   <= w_rd_acc;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = (ld_start ? 1'b0 : err_q) | w_rd_rej;
      ld_ready = 1'b0;
      loaded   = 1'b0;
      unique case (state_q)
         ST_EMPTY: begin
            if (ld_start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end
         end
         ST_LOAD: begin
            ld_ready = 1'b1;
            if (ld_start) begin
               cnt_d = '0;
            end else if (w_wr_fire) begin
               cnt_d = cnt_q + c_cnt_w'(1);
               if (cnt_q == c_last) begin
                  state_d = ST_READY;
               end
            end
         end
         ST_READY: begin
            loaded = 1'b1;
            if (ld_start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   generate
      if (NUM_LANES == 1) begin : g_single
         assign w_wr_row     = ADDR_W'(cnt_q);
         assign w_bank_we[0] = w_wr_fire;
      end else begin : g_multi
         logic [c_lane_w-1:0] w_lane;
         assign w_lane   = cnt_q[c_lane_w-1:0];
         assign w_wr_row = ADDR_W'(cnt_q >> c_lane_w);
         for (genvar k = 0; k < NUM_LANES; k++) begin : g_we
            assign w_bank_we[k] = w_wr_fire && (w_lane == c_lane_w'(k));
         end
      end
   endgenerate

   generate
      for (genvar k = 0; k < NUM_LANES; k++) begin : g_bank
         tf_bank #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .ROWS   (c_bank_depth)
         ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .we_i      (w_bank_we[k]),
            .wr_row_i  (w_wr_row),
            .wr_data_i (ld_data),
            .re_i      (w_rd_acc),
            .rd_row_i  (rd_addr),
            .rd_data_o (w_bank_dout[k])
         );
      end
   endgenerate

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic                        rv2_q;
         logic [NUM_LANES*DATA_W-1:0] rdata_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               rv2_q   <= 1'b0;
               rdata_q <= '0;
            end else begin
               rv2_q <= rv1_q;
               if (rv1_q) begin
                  rdata_q <= w_bank_dout;
               end
            end
         end
         assign rd_valid = rv2_q;
         assign rd_data  = rdata_q;
      end else begin : g_noreg
         assign rd_valid = rv1_q;
         assign rd_data  = w_bank_dout;
      end
   endgenerate

   assign rd_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tf_rom_banked.sv
`default_nettype none
// ==== tb_tf_rom_banked: directed checks of load, banked reads and errors ====
// ==== Rev 1.0                                                            ====
module tb_tf_rom_banked;

   logic        clk;
   logic        rst;

   logic        a_ld_start, a_ld_valid, a_ld_ready, a_loaded;
   logic [27:0] a_ld_data;
   logic        a_rd_en, a_rd_valid, a_rd_err;
   logic [2:0]  a_rd_addr;
   logic [55:0] a_rd_data;

   logic        b_ld_start, b_ld_valid, b_ld_ready, b_loaded;
   logic [27:0] b_ld_data;
   logic        b_rd_en, b_rd_valid, b_rd_err;
   logic [1:0]  b_rd_addr;
   logic [27:0] b_rd_data;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic        en;
      logic [2:0]  addr;
      logic        exp_valid;
      logic [55:0] exp_data;
      logic        exp_err;
   } rvec_t;

   rvec_t tbl [8];

   tf_rom_banked #(
      .ADDR_W(3), .DATA_W(28), .DEPTH(8), .NUM_LANES(2), .OUT_REG(1)
   ) dut_a (
      .clk      (clk),
      .rst      (rst),
      .ld_start (a_ld_start),
      .ld_valid (a_ld_valid),
      .ld_ready (a_ld_ready),
      .ld_data  (a_ld_data),
      .loaded   (a_loaded),
      .rd_en    (a_rd_en),
      .rd_addr  (a_rd_addr),
      .rd_valid (a_rd_valid),
      .rd_data  (a_rd_data),
      .rd_err   (a_rd_err)
   );

   tf_rom_banked #(
      .ADDR_W(2), .DATA_W(28), .DEPTH(4), .NUM_LANES(1), .OUT_REG(0)
   ) dut_b (
      .clk      (clk),
      .rst      (rst),
      .ld_start (b_ld_start),
      .ld_valid (b_ld_valid),
      .ld_ready (b_ld_ready),
      .ld_data  (b_ld_data),
      .loaded   (b_loaded),
      .rd_en    (b_rd_en),
      .rd_addr  (b_rd_addr),
      .rd_valid (b_rd_valid),
      .rd_data  (b_rd_data),
      .rd_err   (b_rd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic a_start();
      a_ld_start = 1'b1;
      cyc();
      a_ld_start = 1'b0;
   endtask

   task automatic a_stream(input logic [27:0] base, input bit gap, input int n_words);
      for (int i = 0; i < n_words; i++) begin
         if (gap) begin
            a_ld_valid = 1'b0;
            a_ld_data  = 28'hFFFFFFF;
            cyc();
         end
         a_ld_valid = 1'b1;
         a_ld_data  = base + 28'(i);
         if (i == 7) chk("loaded_before_last", a_loaded, 0);
         cyc();
      end
      a_ld_valid = 1'b0;
   endtask

   task automatic a_read(input logic [2:0] row, input logic [55:0] exp, input string name);
      a_rd_en   = 1'b1;
      a_rd_addr = row;
      cyc();
      a_rd_en = 1'b0;
      chk({name, "_lat1"}, a_rd_valid, 0);
      cyc();
      chk({name, "_valid"}, a_rd_valid, 1);
      chk({name, "_data"}, a_rd_data, exp);
   endtask

   initial begin
      tbl[0] = '{1'b1, 3'd0, 1'b0, {28'h107, 28'h106}, 1'b0};
      tbl[1] = '{1'b1, 3'd1, 1'b1, {28'h101, 28'h100}, 1'b0};
      tbl[2] = '{1'b1, 3'd2, 1'b1, {28'h103, 28'h102}, 1'b0};
      tbl[3] = '{1'b1, 3'd3, 1'b1, {28'h105, 28'h104}, 1'b0};
      tbl[4] = '{1'b0, 3'd0, 1'b1, {28'h107, 28'h106}, 1'b0};
      tbl[5] = '{1'b1, 3'd4, 1'b0, {28'h107, 28'h106}, 1'b1};
      tbl[6] = '{1'b0, 3'd0, 1'b0, {28'h107, 28'h106}, 1'b1};
      tbl[7] = '{1'b0, 3'd0, 1'b0, {28'h107, 28'h106}, 1'b1};

      rst = 1'b1;
      a_ld_start = 1'b0; a_ld_valid = 1'b0; a_ld_data = '0; a_rd_en = 1'b0; a_rd_addr = '0;
      b_ld_start = 1'b0; b_ld_valid = 1'b0; b_ld_data = '0; b_rd_en = 1'b0; b_rd_addr = '0;
      cyc();
      cyc();
      rst = 1'b0;
      cyc();

      chk("rst_ld_ready", a_ld_ready, 0);
      chk("rst_loaded", a_loaded, 0);
      chk("rst_rd_valid", a_rd_valid, 0);
      chk("rst_rd_data", a_rd_data, 0);
      chk("rst_rd_err", a_rd_err, 0);
      chk("rst_b_rd_data", b_rd_data, 0);

      // Read before any load is rejected.
      a_rd_en = 1'b1; a_rd_addr = 3'd0;
      cyc();
      a_rd_en = 1'b0;
      chk("early_rd_err", a_rd_err, 1);
      cyc();
      chk("early_no_valid1", a_rd_valid, 0);
      cyc();
      chk("early_no_valid2", a_rd_valid, 0);

      // Basic load, no gaps.
      a_start();
      chk("start_clr_err", a_rd_err, 0);
      chk("load_ld_ready", a_ld_ready, 1);
      a_stream(28'h100, 1'b0, 8);
      chk("loaded_rise", a_loaded, 1);
      chk("ready_ld_ready", a_ld_ready, 0);
      a_read(3'd3, {28'h107, 28'h106}, "row3");
      cyc();
      chk("row3_pulse_end", a_rd_valid, 0);

      // Gapped reload, then back-to-back and out-of-range reads from the table.
      a_start();
      a_stream(28'h100, 1'b1, 8);
      chk("gap_loaded", a_loaded, 1);
      for (int i = 0; i < 8; i++) begin
         a_rd_en   = tbl[i].en;
         a_rd_addr = tbl[i].addr;
         cyc();
         chk($sformatf("tbl%0d_valid", i), a_rd_valid, tbl[i].exp_valid);
         chk($sformatf("tbl%0d_data", i), a_rd_data, tbl[i].exp_data);
         chk($sformatf("tbl%0d_err", i), a_rd_err, tbl[i].exp_err);
      end
      a_rd_en = 1'b0;

      a_start();
      chk("start_clr_err2", a_rd_err, 0);

      // Reset in the middle of a load.
      a_stream(28'h100, 1'b0, 5);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mid_rst_ld_ready", a_ld_ready, 0);
      chk("mid_rst_loaded", a_loaded, 0);
      chk("mid_rst_rd_valid", a_rd_valid, 0);
      chk("mid_rst_rd_data", a_rd_data, 0);
      a_rd_en = 1'b1; a_rd_addr = 3'd0;
      cyc();
      a_rd_en = 1'b0;
      chk("post_rst_rd_err", a_rd_err, 1);
      cyc();
      chk("post_rst_no_valid1", a_rd_valid, 0);
      cyc();
      chk("post_rst_no_valid2", a_rd_valid, 0);
      a_start();
      a_stream(28'h100, 1'b0, 8);
      a_read(3'd0, {28'h101, 28'h100}, "after_rst_row0");

      // Read just before a reload returns pre-reload contents.
      a_rd_en = 1'b1; a_rd_addr = 3'd1;
      cyc();
      a_rd_en = 1'b0;
      a_ld_start = 1'b1;
      cyc();
      a_ld_start = 1'b0;
      chk("old_rd_valid", a_rd_valid, 1);
      chk("old_rd_data", a_rd_data, {28'h103, 28'h102});
      chk("reload_loaded_drop", a_loaded, 0);
      a_stream(28'h200, 1'b0, 8);
      a_read(3'd1, {28'h203, 28'h202}, "new_row1");

      // Read coincident with ld_start is rejected.
      a_rd_en = 1'b1; a_rd_addr = 3'd0; a_ld_start = 1'b1;
      cyc();
      a_rd_en = 1'b0; a_ld_start = 1'b0;
      chk("coinc_rd_err", a_rd_err, 1);
      cyc();
      chk("coinc_no_valid1", a_rd_valid, 0);
      cyc();
      chk("coinc_no_valid2", a_rd_valid, 0);

      // A word offered with ld_start in LOAD is discarded.
      a_ld_valid = 1'b1; a_ld_data = 28'h3FF; a_ld_start = 1'b1;
      cyc();
      a_ld_start = 1'b0;
      a_stream(28'h300, 1'b0, 8);
      a_read(3'd0, {28'h301, 28'h300}, "discard_row0");
      a_read(3'd3, {28'h307, 28'h306}, "discard_row3");

      // Single lane, no output register.
      chk("b_not_loaded", b_loaded, 0);
      b_ld_start = 1'b1;
      cyc();
      b_ld_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         b_ld_valid = 1'b1;
         b_ld_data  = 28'hA + 28'(i);
         cyc();
      end
      b_ld_valid = 1'b0;
      chk("b_loaded", b_loaded, 1);
      b_rd_en = 1'b1; b_rd_addr = 2'd2;
      cyc();
      b_rd_en = 1'b0;
      chk("b_row2_valid", b_rd_valid, 1);
      chk("b_row2_data", b_rd_data, 28'hC);
      cyc();
      chk("b_hold_valid", b_rd_valid, 0);
      chk("b_hold_data", b_rd_data, 28'hC);
      b_rd_en = 1'b1; b_rd_addr = 2'd3;
      cyc();
      b_rd_en = 1'b0;
      chk("b_row3_data", b_rd_data, 28'hD);
      chk("b_no_err", b_rd_err, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
